// File: rtl/float_mult_pipe.sv
// Three-stage pipelined floating-point multiplier with round-to-nearest-even,
// IEEE-style special-value handling, status flags and a valid/ready stream interface.
module float_mult_pipe #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1+EXP_W+MAN_W-1:0]     float_a,
  input  logic [1+EXP_W+MAN_W-1:0]     float_b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [1+EXP_W+MAN_W-1:0]     product,
  output logic                         flag_overflow,
  output logic                         flag_underflow,
  output logic                         flag_invalid,
  output logic                         flag_inexact
);

  localparam int unsigned W    = 1 + EXP_W + MAN_W;
  localparam int unsigned EW   = EXP_W + 2;
  localparam int unsigned PW   = 2 * MAN_W + 2;
  localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int unsigned EMAX = (1 << EXP_W) - 1;

  typedef enum logic [1:0] {CLS_NORM, CLS_NAN, CLS_INF, CLS_ZERO} cls_t;

  logic en;

  // stage 1 registers
  logic                 s1_valid;
  logic                 s1_sign;
  cls_t                 s1_cls;
  logic signed [EW-1:0] s1_exp;
  logic [MAN_W:0]       s1_ma;
  logic [MAN_W:0]       s1_mb;

  // stage 2 registers
  logic                 s2_valid;
  logic                 s2_sign;
  cls_t                 s2_cls;
  logic signed [EW-1:0] s2_exp;
  logic [MAN_W-1:0]     s2_frac;
  logic                 s2_guard;
  logic                 s2_sticky;

  // combinational per-stage results
  logic [EXP_W-1:0]     ea_c;
  logic [EXP_W-1:0]     eb_c;
  logic                 zero_a_c, zero_b_c, inf_a_c, inf_b_c, nan_a_c, nan_b_c;
  cls_t                 cls_c;
  logic signed [EW-1:0] e1_c;
  logic [PW-1:0]        prod_c;
  logic [PW-2:0]        norm_c;
  logic signed [EW-1:0] e2_c;
  logic                 round_up_c;
  logic [MAN_W:0]       rnd_c;
  logic signed [EW-1:0] e3_c;
  logic [W-1:0]         p3_c;
  logic                 ovf_c, unf_c, inv_c, inx_c;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage 1: classify operands and form the biased exponent sum
  always_comb begin
    ea_c     = float_a[W-2 -: EXP_W];
    eb_c     = float_b[W-2 -: EXP_W];
    zero_a_c = (ea_c == '0);
    zero_b_c = (eb_c == '0);
    inf_a_c  = (ea_c == EXP_W'(EMAX)) && (float_a[MAN_W-1:0] == '0);
    inf_b_c  = (eb_c == EXP_W'(EMAX)) && (float_b[MAN_W-1:0] == '0);
    nan_a_c  = (ea_c == EXP_W'(EMAX)) && (float_a[MAN_W-1:0] != '0);
    nan_b_c  = (eb_c == EXP_W'(EMAX)) && (float_b[MAN_W-1:0] != '0);
    cls_c    = CLS_NORM;
    if (nan_a_c || nan_b_c || (inf_a_c && zero_b_c) || (inf_b_c && zero_a_c))
      cls_c = CLS_NAN;
    else if (inf_a_c || inf_b_c)
      cls_c = CLS_INF;
    else if (zero_a_c || zero_b_c)
      cls_c = CLS_ZERO;
    e1_c = $signed(EW'(ea_c) + EW'(eb_c) - EW'(BIAS));
  end

  // Stage 2: full mantissa product, normalise to 1.x, extract guard/sticky
  always_comb begin
    prod_c = PW'(s1_ma) * PW'(s1_mb);
    norm_c = prod_c[PW-1] ? prod_c[PW-2:0] : {prod_c[PW-3:0], 1'b0};
    e2_c   = s1_exp + $signed(EW'(prod_c[PW-1]));
  end

  // Stage 3: round to nearest even, range check, special-case override
  always_comb begin
    round_up_c = s2_guard && (s2_sticky || s2_frac[0]);
    rnd_c      = {1'b0, s2_frac} + (MAN_W+1)'(round_up_c);
    e3_c       = s2_exp + $signed(EW'(rnd_c[MAN_W]));
    p3_c       = {s2_sign, e3_c[EXP_W-1:0], rnd_c[MAN_W-1:0]};
    ovf_c      = 1'b0;
    unf_c      = 1'b0;
    inv_c      = 1'b0;
    inx_c      = s2_guard || s2_sticky;
    case (s2_cls)
      CLS_NAN: begin
        p3_c  = {1'b0, {EXP_W{1'b1}}, 1'b1, (MAN_W-1)'(0)};
        inv_c = 1'b1;
        inx_c = 1'b0;
      end
      CLS_INF: begin
        p3_c  = {s2_sign, {EXP_W{1'b1}}, MAN_W'(0)};
        inx_c = 1'b0;
      end
      CLS_ZERO: begin
        p3_c  = {s2_sign, (EXP_W+MAN_W)'(0)};
        inx_c = 1'b0;
      end
      default: begin
        if (e3_c >= $signed(EW'(EMAX))) begin
          p3_c  = {s2_sign, {EXP_W{1'b1}}, MAN_W'(0)};
          ovf_c = 1'b1;
          inx_c = 1'b1;
        end else if (e3_c <= $signed(EW'(0))) begin
          p3_c  = {s2_sign, (EXP_W+MAN_W)'(0)};
          unf_c = 1'b1;
          inx_c = 1'b1;
        end
      end
    endcase
  end

  // Pipeline registers; every stage advances together on en
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid       <= 1'b0;
      s1_sign        <= 1'b0;
      s1_cls         <= CLS_NORM;
      s1_exp         <= '0;
      s1_ma          <= '0;
      s1_mb          <= '0;
      s2_valid       <= 1'b0;
      s2_sign        <= 1'b0;
      s2_cls         <= CLS_NORM;
      s2_exp         <= '0;
      s2_frac        <= '0;
      s2_guard       <= 1'b0;
      s2_sticky      <= 1'b0;
      out_valid      <= 1'b0;
      product        <= '0;
      flag_overflow  <= 1'b0;
      flag_underflow <= 1'b0;
      flag_invalid   <= 1'b0;
      flag_inexact   <= 1'b0;
    end else if (en) begin
      s1_valid       <= in_valid;
      s1_sign        <= float_a[W-1] ^ float_b[W-1];
      s1_cls         <= cls_c;
      s1_exp         <= e1_c;
      s1_ma          <= {1'b1, float_a[MAN_W-1:0]};
      s1_mb          <= {1'b1, float_b[MAN_W-1:0]};
      s2_valid       <= s1_valid;
      s2_sign        <= s1_sign;
      s2_cls         <= s1_cls;
      s2_exp         <= e2_c;
      s2_frac        <= norm_c[PW-2 -: MAN_W];
      s2_guard       <= norm_c[MAN_W];
      s2_sticky      <= |norm_c[MAN_W-1:0];
      out_valid      <= s2_valid;
      product        <= s2_valid ? p3_c : '0;
      flag_overflow  <= s2_valid && ovf_c;
      flag_underflow <= s2_valid && unf_c;
      flag_invalid   <= s2_valid && inv_c;
      flag_inexact   <= s2_valid && inx_c;
    end
  end

endmodule

// File: doc/float_mult_pipe.md
Name: float_mult_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point multiplier. Successor to the team's combinational half-precision multiplier.
- Adds configurable exponent/mantissa widths, round-to-nearest-even, overflow/NaN/infinity handling, status flags and a valid/ready stream interface.
- Sits in the ANN datapath between weight/activation fetch and the accumulator. Default configuration is fp16.

Parameters:
- EXP_W, 5, exponent field width (bits).
- MAN_W, 10, stored mantissa width (bits), implicit leading 1 not stored.
- Derived localparams:
  - W = 1+EXP_W+MAN_W (word width).
  - BIAS = 2^(EXP_W-1)-1.
  - EMAX = 2^EXP_W-1 (all-ones exponent).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts operands this cycle.
- float_a  in  W  operand A {sign, exp, man}.
- float_b  in  W  operand B.
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts product.
- product  out  W  result.
- flag_overflow  out  1  result saturated to infinity.
- flag_underflow  out  1  nonzero result flushed to zero.
- flag_invalid  out  1  NaN result produced.
- flag_inexact  out  1  rounding discarded nonzero bits.

Behaviour:
- Single clock. Reset is synchronous and active-low on rst_n; clock is clk.
- Reset:
  - All stage valids, out_valid, product and all flags go to 0.
  - Reset mid-operation discards in-flight data; no output follows reset release until new inputs are accepted.
- Pipeline and handshake:
  - 3 stages, latency exactly 3 cycles from accepted input to out_valid when out_ready is held high. Throughput 1 per cycle.
  - Global enable en = !out_valid || out_ready. in_ready = en (combinational). All stages advance only when en=1.
  - Bubbles are not collapsed.
  - Input transfer occurs on in_valid && in_ready. Output transfer occurs on out_valid && out_ready.
  - While out_valid=1 and out_ready=0, product and flags hold stable.
- Stage 1 (classify):
  - sign = a.s ^ b.s.
  - Zero: exp==0. Denormal inputs are treated as zero; this does not set underflow.
  - Inf: exp==EMAX, man==0. NaN: exp==EMAX, man!=0.
  - Signed exponent sum e = ea+eb-BIAS, EXP_W+2 bits wide, so it cannot overflow.
- Stage 2 (multiply and normalise):
  - Full (MAN_W+1)x(MAN_W+1) product, 2*MAN_W+2 bits.
  - If MSB is set: take the upper fraction bits after the MSB and set e=e+1. Otherwise use the bits after MSB-1.
  - Guard = next bit below the kept fraction. Sticky = OR of all remaining lower bits.
- Stage 3 (round and pack):
  - RNE: round up iff guard && (sticky || lsb).
  - Mantissa carry-out sets mantissa to 0 and increments e.
  - inexact = guard || sticky.
  - e >= EMAX: product={sign,EMAX,0}, overflow=1, inexact=1.
  - e <= 0: product={sign,0,0}, underflow=1, inexact=1.
- Special-case priority (highest first):
  1. Any NaN input, or inf x zero: product = canonical qNaN {0,EMAX,1,0...}, invalid=1, other flags 0.
  2. Inf x finite-nonzero or inf x inf: {sign,EMAX,0}, no flags.
  3. Either operand zero: {sign,0,0}, no flags.
- Flags are registered alongside product and are valid only when out_valid=1. Flags are 0 when out_valid=0 after reset.

Test Plan:
- Basic product and latency: 0x3C00 x 0x4000 -> 0x4000 exactly 3 cycles later, all flags 0. Then 0x3E00 x 0x3E00 -> 0x4080.
- Rounding:
  - 0x3C01 x 0x3C01 -> 0x3C02, inexact=1 (round down, sticky only).
  - 0x3C01 x 0x3E00 -> 0x3E02, inexact=1 (tie, odd -> even up).
- Range limits:
  - 0x7BFF x 0x4000 -> 0x7C00, overflow=1.
  - 0x0400 x 0x3800 -> 0x0000, underflow=1.
  - 0x8400 x 0x3800 -> 0x8000, underflow=1.
- Specials:
  - 0x7C00 x 0x0000 -> 0x7E00, invalid=1.
  - 0xFC00 x 0x4000 -> 0xFC00.
  - 0x7C01 x 0x3C00 -> 0x7E00, invalid=1.
  - 0x0001 x 0x3C00 -> 0x0000, no flags.
- Backpressure: stream 6 back-to-back pairs, drop out_ready for 4 cycles mid-stream.
  - in_ready falls in the same cycle.
  - product holds stable while stalled.
  - All 6 results arrive in order, none lost or duplicated.
- Reset mid-stream: assert rst_n=0 for 1 cycle with 2 operations in flight.
  - Next cycle out_valid=0, product=0, flags=0.
  - No stale results appear afterwards.
  - Repeat with EXP_W=8, MAN_W=23: 0x3F800000 x 0x40000000 -> 0x40000000.
